// File: rtl/delay_ram_ctrl.sv
// Controller for the circular coefficient delay RAM between NTT/INTT stages.
// It accepts N coefficients per job and issues RAM reads so that the output
// stream lags the input stream by D samples rather than D cycles. Input stalls
// are therefore tolerated. Data never passes through this block.
module delay_ram_ctrl #(
  parameter  int SIZE = 256,
  parameter  int N    = 256,
  localparam int AW   = $clog2(SIZE),
  localparam int DW   = $clog2(SIZE + 1),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] delay,
  output logic          cfg_err,
  output logic          in_ready,
  input  logic          in_valid,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  // Common width for comparing an occupancy count against the delay.
  localparam int XW = (CW > DW) ? CW : DW;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state;
  logic [DW-1:0] d_reg;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [XW-1:0] occ;
  logic          running;
  logic          wr_fire;
  logic          rd_fire;
  logic          delay_bad;
  logic [AW-1:0] wptr_nxt, rptr_nxt;

  assign running   = (state == RUN);
  assign in_ready  = running && (in_cnt < CW'(N));
  // NOTE: ram_we is a combinational AND with in_valid, so a write lands in the
  // same cycle the coefficient is offered; registering it would skew the data.
  assign wr_fire   = in_valid && in_ready;
  assign occ       = XW'(in_cnt - out_cnt);
  // Reads use the counts from before this cycle's write: a sample becomes
  // readable only once D newer ones exist, or once the whole job is in.
  assign rd_fire   = running && (out_cnt < in_cnt) &&
                     ((occ >= XW'(d_reg)) || (in_cnt == CW'(N)));
  assign delay_bad = (delay == '0) || (delay > DW'(SIZE));

  assign wptr_nxt  = (wptr == AW'(SIZE - 1)) ? '0 : wptr + AW'(1);
  assign rptr_nxt  = (rptr == AW'(SIZE - 1)) ? '0 : rptr + AW'(1);

  assign ram_we    = wr_fire;
  assign ram_waddr = wptr;
  assign ram_re    = rd_fire;
  assign ram_raddr = rptr;

  // Job sequencer: pointers, counters, and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_reg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see the values from
      // before this edge; a blocking = would let later lines see new values.
      out_valid <= rd_fire;
      cfg_err   <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (delay_bad) begin
              cfg_err <= 1'b1;
            end else begin
              d_reg   <= delay;
              wptr    <= '0;
              rptr    <= '0;
              in_cnt  <= '0;
              out_cnt <= '0;
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (wr_fire) begin
            wptr   <= wptr_nxt;
            in_cnt <= in_cnt + CW'(1);
          end
          if (rd_fire) begin
            rptr    <= rptr_nxt;
            out_cnt <= out_cnt + CW'(1);
            if (out_cnt == CW'(N - 1)) begin
              done  <= 1'b1;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_ram_ctrl.sv
// Bench for delay_ram_ctrl: a sample-count reference model predicts every
// control output each cycle, and a read-before-write RAM attached to the DUT
// addresses carries data so the output order can be checked end to end.
module tb_delay_ram_ctrl;

  localparam int SIZE = 256;
  localparam int N    = 256;
  localparam int AW   = $clog2(SIZE);
  localparam int DW   = $clog2(SIZE + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] delay;
  logic          cfg_err;
  logic          in_ready;
  logic          in_valid;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [31:0] wdata;
  logic [31:0] ram_q;
  logic [31:0] mem [SIZE];

  delay_ram_ctrl #(.SIZE(SIZE), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .delay     (delay),
    .cfg_err   (cfg_err),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Attached RAM: registered read, old data returned on address collision.
  always @(posedge clk) begin
    if (ram_re) ram_q <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: counts of samples written and read in the current job.
  bit m_active, m_ov, m_done, m_busy, m_cfg;
  int m_w, m_r, m_d;
  int m_q [$];

  // Observations of the DUT for per-job timing pins.
  int first_we, first_re, first_waddr, first_raddr, done_cyc;
  int n_ov, n_done, n_cfg, n_we, n_re, max_occ, n_coll;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_ov = 0; m_done = 0; m_busy = 0; m_cfg = 0;
    m_w = 0; m_r = 0; m_d = 0;
    m_q.delete();
  endtask

  task automatic clear_obs();
    first_we = -1; first_re = -1; first_waddr = -1; first_raddr = -1; done_cyc = -1;
    n_ov = 0; n_done = 0; n_cfg = 0; n_we = 0; n_re = 0; max_occ = 0; n_coll = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare shortly after,
  // then advance the model across the rising edge.
  task automatic cycle(input bit st, input int dl, input bit iv);
    bit          e_rdy, e_we, e_re, fin, idle;
    logic [31:0] e_data;
    int          occ;
    start    = st;
    delay    = DW'(dl);
    in_valid = iv;
    wdata    = $urandom;
    #2;
    e_rdy = m_active && (m_w < N);
    e_we  = e_rdy && iv;
    e_re  = m_active && (m_r < m_w) && (((m_w - m_r) >= m_d) || (m_w == N));
    check("in_ready", in_ready, e_rdy);
    check("ram_we", ram_we, e_we);
    if (e_we) check("ram_waddr", ram_waddr, m_w % SIZE);
    check("ram_re", ram_re, e_re);
    if (e_re) check("ram_raddr", ram_raddr, m_r % SIZE);
    check("out_valid", out_valid, m_ov);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    check("cfg_err", cfg_err, m_cfg);
    if (m_ov) begin
      e_data = (m_q.size() > 0) ? m_q.pop_front() : 'x;
      check("ram_data", ram_q, e_data);
    end
    occ = n_we - n_re;
    if (n_we < N && occ > max_occ) max_occ = occ;
    if (ram_we) begin
      if (first_we < 0) begin first_we = cyc; first_waddr = ram_waddr; end
      n_we++;
    end
    if (ram_re) begin
      if (first_re < 0) begin first_re = cyc; first_raddr = ram_raddr; end
      n_re++;
    end
    if (ram_we && ram_re && ram_waddr == ram_raddr) n_coll++;
    if (out_valid) n_ov++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (cfg_err) n_cfg++;

    @(posedge clk);
    fin  = e_re && (m_r == N - 1);
    idle = !m_active && !m_done;
    if (e_we) begin m_q.push_back(wdata); m_w++; end
    if (e_re) m_r++;
    m_ov   = e_re;
    m_done = fin;
    m_cfg  = 0;
    if (st && idle) begin
      if (dl == 0 || dl > SIZE) m_cfg = 1;
      else begin m_active = 1; m_w = 0; m_r = 0; m_d = dl; end
    end
    if (fin) m_active = 0;
    m_busy = m_active || fin;
    cyc++;
    @(negedge clk);
  endtask

  // Start a job and run it until the model says it is over (or abort_w
  // coefficients have been written, when abort_w is non-negative).
  task automatic run_job(input int d, input bit rnd, input int busy_start, input int abort_w);
    int guard = 0;
    clear_obs();
    cycle(1'b1, d, 1'b0);
    while ((m_active || m_busy) && guard < 4000 && !(abort_w >= 0 && m_w >= abort_w)) begin
      cycle(guard == busy_start, 5, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
    check("job_bounded", guard < 4000, 1);
    if (abort_w < 0) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_waddr"}, ram_waddr, 0);
    check({tag, "_ram_re"}, ram_re, 0);
    check({tag, "_ram_raddr"}, ram_raddr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Asynchronous reset asserted between edges, with in_valid held high.
  task automatic pulse_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    #2;
    zero_checks("midjob_rst");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; delay = '0; wdata = '0;
    model_clear();
    clear_obs();
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    #2;
    zero_checks("reset");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    cycle(1'b0, 0, 1'b0);

    // D=4, continuous input.
    run_job(4, 1'b0, -1, -1);
    check("d4_first_re_lag", first_re - first_we, 4);
    check("d4_done_lag", done_cyc - first_we, 260);
    check("d4_out_valid_count", n_ov, 256);
    check("d4_done_count", n_done, 1);
    check("d4_first_raddr", first_raddr, 0);

    // D=SIZE, continuous input: full fill, then drain.
    run_job(256, 1'b0, -1, -1);
    check("d256_first_re_lag", first_re - first_we, 256);
    check("d256_done_lag", done_cyc - first_we, 512);
    check("d256_out_valid_count", n_ov, 256);
    check("d256_collisions", n_coll, 0);

    // D=3, 50% input duty.
    run_job(3, 1'b1, -1, -1);
    check("d3_out_valid_count", n_ov, 256);
    check("d3_done_count", n_done, 1);
    check("d3_max_occ_le_3", max_occ <= 3, 1);

    // Illegal delays.
    clear_obs();
    cycle(1'b1, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 257, 1'b1);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);
    check("cfg_err_pulses", n_cfg, 2);
    check("cfg_no_ram_we", n_we, 0);
    check("cfg_no_ram_re", n_re, 0);

    // Reset after 100 coefficients, then a clean D=8 job.
    run_job(5, 1'b0, -1, 100);
    pulse_reset();
    check("abort_no_done", n_done, 0);
    run_job(8, 1'b0, -1, -1);
    check("d8_first_waddr", first_waddr, 0);
    check("d8_first_re_lag", first_re - first_we, 8);
    check("d8_done_lag", done_cyc - first_we, 264);

    // start while busy is ignored.
    run_job(6, 1'b1, 20, -1);
    check("busy_start_done_count", n_done, 1);
    check("busy_start_no_cfg_err", n_cfg, 0);
    check("busy_start_out_valid_count", n_ov, 256);

    // Back-to-back: start accepted right after done.
    run_job(2, 1'b0, -1, -1);
    check("d2_done_lag", done_cyc - first_we, 258);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_ram_ctrl.md
# delay_ram_ctrl

Sequencing controller for the circular coefficient delay RAM used between NTT/INTT butterfly stages. It accepts one polynomial of N coefficients per job and drives the write and read addresses of a simple dual-port RAM so that the output stream lags the input stream by a programmable D coefficients, counted in samples rather than cycles. Input stalls are therefore tolerated. It reports job progress (busy/done) to the stage scheduler. Data never passes through this block; only RAM control does.

## Interface
- SIZE, 256, RAM depth in entries (power of two not required)
- N, 256, coefficients per job
- AW = $clog2(SIZE) (localparam), DW = $clog2(SIZE+1) (localparam), CW = $clog2(N+1) (localparam)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- delay  in  DW  requested delay D in coefficients; legal range 1..SIZE; sampled with start
- cfg_err  out  1  one-cycle pulse when start arrives in IDLE with D=0 or D>SIZE; job not started
- in_ready  out  1  high in RUN while fewer than N coefficients accepted
- in_valid  in  1  coefficient present on RAM write-data this cycle; ignored unless in_ready
- ram_we  out  1  RAM write enable (= in_valid & in_ready)
- ram_waddr  out  AW  write address
- ram_re  out  1  RAM read enable
- ram_raddr  out  AW  read address
- out_valid  out  1  RAM read data valid this cycle (registered ram_re)
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse coincident with the last out_valid of a job

## Operation
- Internal registers: state, D_reg (DW), wptr/rptr (AW, wrap SIZE-1→0), in_cnt/out_cnt (CW).
- Reset values: state=IDLE; all pointers, counters and D_reg = 0; all outputs 0.
- IDLE:
  - start with legal delay → latch D_reg, clear pointers and counters, go to RUN.
  - start with illegal delay → pulse cfg_err, stay in IDLE.
- RUN:
  - Write: on in_valid & in_ready, drive ram_we=1 and ram_waddr=wptr, then increment wptr and in_cnt.
  - Read: ram_re = (out_cnt < in_cnt) & ((in_cnt − out_cnt ≥ D_reg) | (in_cnt == N)).
    - The condition uses registered counts, i.e. values before this cycle's write.
    - When ram_re is high, ram_raddr=rptr, then increment rptr and out_cnt.
  - When ram_re fires with out_cnt == N−1, go to FLUSH.
- FLUSH: lasts one cycle, in which out_valid=1 and done=1; next state is IDLE.
- Occupancy (in_cnt − out_cnt) never exceeds D_reg ≤ SIZE, so in_ready is never throttled by fullness.
- Same-cycle collision: when D=SIZE, ram_waddr == ram_raddr with both enables high.
  - The attached RAM must return the old (read-before-write) data in this case.
  - This is the RAM's contract; the controller does nothing special.
- start during RUN or FLUSH is ignored; no cfg_err.
- rst asserted mid-job: job is abandoned immediately and all state returns to reset values. No done is produced.

## Timing
- start at cycle S → in_ready high from S+1.
- Continuous input with first write at T0:
  - First ram_re at T0+D; first out_valid at T0+D+1.
  - Reads are then back-to-back; last out_valid and done at T0+N+D.
  - busy drops at T0+N+D+1.
- Input stall: reads pause once occupancy < D, until all N coefficients have been written; after that, reads drain back-to-back.
- out_valid is exactly ram_re delayed by one cycle. Downstream samples RAM data on out_valid.
- Back-to-back jobs: start is accepted in the cycle after done (state IDLE).

## Test plan
- D=4, N=256, in_valid held high from first in_ready:
  - ram_re first at T0+4; out_valid 256 consecutive cycles T0+5..T0+260.
  - done at T0+260; raddr sequence 0..255.
- D=SIZE=256, N=256, continuous input:
  - No reads until all 256 written; then 256 reads draining.
  - Check raddr==waddr collision cases; data out equals data in, in order.
- D=3, in_valid random 50% duty:
  - Output order and values match input.
  - Occupancy never exceeds 3 until the drain phase; exactly 256 out_valid, one done.
- start with delay=0, then delay=257 (SIZE=256):
  - cfg_err pulses each time; busy stays 0; no RAM enables.
- rst pulsed after 100 coefficients:
  - All outputs 0 next cycle; no done.
  - A following start with D=8 runs a clean job starting at waddr 0.
- start asserted while busy: ignored, no cfg_err, job completes normally.
